// File: rtl/diamond_pkg.sv
// diamond_pkg: diamond table, diamond record type and scan FSM states shared by the scan controller
package diamond_pkg;
  localparam int N_DIAMOND = 6;
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       is_red;
  } diamond_t;
  localparam diamond_t DIAMOND_TABLE [N_DIAMOND] = '{
    '{10'd460, 10'd408, 1'b0},
    '{10'd366, 10'd238, 1'b0},
    '{10'd38,  10'd90,  1'b0},
    '{10'd330, 10'd408, 1'b1},
    '{10'd300, 10'd220, 1'b1},
    '{10'd190, 10'd42,  1'b1}
  };
  typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t;
endpackage

// File: rtl/diamond_scan_ctrl_if.sv
// diamond_scan_ctrl_if: frame_start/level_clear and player geometry in, collected masks/counts/scan status out
interface diamond_scan_ctrl_if;
  logic       frame_start, level_clear;
  logic [9:0] p0_x, p0_y, p1_x, p1_y;
  logic [6:0] p0_w, p0_h, p1_w, p1_h;
  logic [2:0] blue_mask, red_mask;
  logic [3:0] num_blue, num_red;
  logic       all_collected, scan_busy, scan_done, new_collect, overrun;
  modport master (
    output frame_start, level_clear, p0_x, p0_y, p1_x, p1_y, p0_w, p0_h, p1_w, p1_h,
    input  blue_mask, red_mask, num_blue, num_red, all_collected, scan_busy, scan_done, new_collect, overrun
  );
  modport slave (
    input  frame_start, level_clear, p0_x, p0_y, p1_x, p1_y, p0_w, p0_h, p1_w, p1_h,
    output blue_mask, red_mask, num_blue, num_red, all_collected, scan_busy, scan_done, new_collect, overrun
  );
endinterface

// File: rtl/hitbox_probe.sv
// hitbox_probe: combinational 8-point player probe against one diamond box; in px/py/pw/ph, dx/dy, out hit
module hitbox_probe #(
  parameter int DSIZE    = 20,
  parameter int PROBE_DX = 8,
  parameter int PROBE_DY = 4
) (
  input  logic [9:0] px,
  input  logic [9:0] py,
  input  logic [6:0] pw,
  input  logic [6:0] ph,
  input  logic [9:0] dx,
  input  logic [9:0] dy,
  output logic       hit
);
  localparam logic [9:0]  OX = 10'(PROBE_DX);
  localparam logic [9:0]  OY = 10'(PROBE_DY);
  localparam logic [10:0] SZ = 11'(DSIZE);
  logic [9:0] hw, hh;
  logic [9:0] qx [8];
  logic [9:0] qy [8];
  assign hw = 10'(pw >> 1);
  assign hh = 10'(ph >> 1);
  assign qx = '{px, px, px - hw, px + hw, px - OX, px + OX, px - OX, px + OX};
  assign qy = '{py - hh, py + hh, py, py, py + hh - OY, py + hh + OY, py - hh - OY, py - hh + OY};
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < 8; i++)
      hit = hit | (qx[i] >= dx && {1'b0, qx[i]} < {1'b0, dx} + SZ && qy[i] >= dy && {1'b0, qy[i]} < {1'b0, dy} + SZ);
  end
endmodule

// File: rtl/diamond_scan_ctrl.sv
// diamond_scan_ctrl: per-frame diamond pickup scanner; ports Clk, Reset, bus (slave: players in, masks/counts/status out)
module diamond_scan_ctrl
  import diamond_pkg::*;
#(
  parameter int DSIZE    = 20,
  parameter int PROBE_DX = 8,
  parameter int PROBE_DY = 4
) (
  input logic Clk,
  input logic Reset,
  diamond_scan_ctrl_if.slave bus
);
  localparam logic [2:0] LAST = 3'(N_DIAMOND - 1);
  scan_state_t state;
  logic [2:0] idx;
  logic [9:0] sx [2];
  logic [9:0] sy [2];
  logic [6:0] sw [2];
  logic [6:0] sh [2];
  logic [5:0] got, got_nxt;
  logic [3:0] num_blue, num_red;
  logic all_collected, scan_busy, scan_done, new_collect, overrun;
  logic sel, hit, fresh;
  diamond_t d;
  assign d = DIAMOND_TABLE[idx];
  // red diamonds belong to player 0, blue to player 1
  assign sel = ~d.is_red;
  hitbox_probe #(.DSIZE(DSIZE), .PROBE_DX(PROBE_DX), .PROBE_DY(PROBE_DY)) u_probe (
    .px(sx[sel]), .py(sy[sel]), .pw(sw[sel]), .ph(sh[sel]), .dx(d.x), .dy(d.y), .hit(hit)
  );
  assign fresh   = state == SCAN && hit && !got[idx];
  assign got_nxt = got | (6'(fresh) << idx);
  assign bus.blue_mask     = got[2:0];
  assign bus.red_mask      = got[5:3];
  assign bus.num_blue      = num_blue;
  assign bus.num_red       = num_red;
  assign bus.all_collected = all_collected;
  assign bus.scan_busy     = scan_busy;
  assign bus.scan_done     = scan_done;
  assign bus.new_collect   = new_collect;
  assign bus.overrun       = overrun;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      idx <= '0;
      sx <= '{default: '0};
      sy <= '{default: '0};
      sw <= '{default: '0};
      sh <= '{default: '0};
      got <= '0;
      num_blue <= '0;
      num_red <= '0;
      all_collected <= 1'b0;
      scan_busy <= 1'b0;
      scan_done <= 1'b0;
      new_collect <= 1'b0;
      overrun <= 1'b0;
    end else if (bus.level_clear) begin
      state <= IDLE;
      idx <= '0;
      got <= '0;
      num_blue <= '0;
      num_red <= '0;
      all_collected <= 1'b0;
      scan_busy <= 1'b0;
      scan_done <= 1'b0;
      new_collect <= 1'b0;
      overrun <= 1'b0;
    end else begin
      got <= got_nxt;
      all_collected <= &got_nxt;
      new_collect <= fresh;
      num_blue <= num_blue + 4'(fresh & ~d.is_red);
      num_red <= num_red + 4'(fresh & d.is_red);
      scan_done <= state == SCAN && idx == LAST;
      overrun <= overrun | (bus.frame_start && state != IDLE);
      if (state == IDLE && bus.frame_start) begin
        sx <= '{bus.p0_x, bus.p1_x};
        sy <= '{bus.p0_y, bus.p1_y};
        sw <= '{bus.p0_w, bus.p1_w};
        sh <= '{bus.p0_h, bus.p1_h};
        idx <= '0;
        state <= SCAN;
        scan_busy <= 1'b1;
      end else if (state == SCAN) begin
        idx <= idx == LAST ? '0 : idx + 3'd1;
        state <= idx == LAST ? DONE : SCAN;
      end else if (state == DONE) begin
        state <= IDLE;
        scan_busy <= 1'b0;
      end
    end
endmodule
